// File: rtl/pcileech_tlp_tx_arb.sv
// Two-source, packet-atomic TLP transmit arbiter with a registered skid stage toward the core.
// Define PCILEECH_TX_ARB_RR_EN for round-robin tie-breaking; otherwise source B wins ties.
module pcileech_tlp_tx_arb #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic                clk_pcie,
   input  logic                rst_n,
   input  logic [DATA_W-1:0]   a_data,
   input  logic [DATA_W/8-1:0] a_keep,
   input  logic                a_last,
   input  logic                a_valid,
   output logic                a_ready,
   input  logic [DATA_W-1:0]   b_data,
   input  logic [DATA_W/8-1:0] b_keep,
   input  logic                b_last,
   input  logic                b_valid,
   output logic                b_ready,
   output logic [DATA_W-1:0]   tx_data,
   output logic [DATA_W/8-1:0] tx_keep,
   output logic                tx_last,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic [CNT_W-1:0]    tlp_count,
   output logic                arb_busy
);

   localparam int KEEP_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

   state_t              state;
   logic                last_gnt;   // 1 = source B
   logic                skid_full;
   logic [DATA_W-1:0]   skid_data;
   logic [KEEP_W-1:0]   skid_keep;
   logic                skid_last;

   logic                sel_b;
   logic                acc;
   logic                pick_b;
   logic [DATA_W-1:0]   in_data;
   logic [KEEP_W-1:0]   in_keep;
   logic                in_last;

   // Readies decode only registered state, keeping tx_ready off the source paths.
   assign a_ready  = (state == GNT_A) && !skid_full;
   assign b_ready  = (state == GNT_B) && !skid_full;
   assign arb_busy = (state != IDLE);

   always_comb begin
      sel_b   = (state == GNT_B);
      acc     = (a_valid && a_ready) || (b_valid && b_ready);
      in_data = sel_b ? b_data : a_data;
      in_keep = sel_b ? b_keep : a_keep;
      in_last = sel_b ? b_last : a_last;
`ifdef PCILEECH_TX_ARB_RR_EN
      pick_b  = b_valid && (!a_valid || !last_gnt);
`else
      pick_b  = b_valid;
`endif
   end

   always_ff @(posedge clk_pcie or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (a_valid || b_valid) begin
                  state    <= pick_b ? GNT_B : GNT_A;
                  last_gnt <= pick_b;
               end
            end
            GNT_A, GNT_B: begin
               if (acc && in_last)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_pcie or negedge rst_n) begin
      if (!rst_n) begin
         tx_valid  <= 1'b0;
         tx_data   <= '0;
         tx_keep   <= '0;
         tx_last   <= 1'b0;
         skid_full <= 1'b0;
         skid_data <= '0;
         skid_keep <= '0;
         skid_last <= 1'b0;
      end else if (tx_valid && tx_ready) begin
         // acc cannot coincide with skid_full, since readies are gated by it.
         if (skid_full) begin
            tx_data   <= skid_data;
            tx_keep   <= skid_keep;
            tx_last   <= skid_last;
            skid_full <= 1'b0;
         end else if (acc) begin
            tx_data <= in_data;
            tx_keep <= in_keep;
            tx_last <= in_last;
         end else begin
            tx_valid <= 1'b0;
         end
      end else if (acc) begin
         if (!tx_valid) begin
            tx_data  <= in_data;
            tx_keep  <= in_keep;
            tx_last  <= in_last;
            tx_valid <= 1'b1;
         end else begin
            skid_data <= in_data;
            skid_keep <= in_keep;
            skid_last <= in_last;
            skid_full <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_pcie or negedge rst_n) begin
      if (!rst_n)
         tlp_count <= '0;
      else if (tx_valid && tx_ready && tx_last)
         tlp_count <= tlp_count + 1'b1;
   end

endmodule
